fifo_resultados_div: RTL and testbench

Result buffer placed directly downstream of the pipelined divider. It captures each `{Coc, Res}` pair on the divider's one-cycle `Done` pulse and stores it in a first-word-fall-through FIFO. Results are presented to the consumer over a valid/ready handshake. The divider pipeline cannot stall, so the block also tracks divisions in flight and issues a `Puede_empezar` credit signal that tells the upstream issuer when it may assert `Start` without risking loss of a result.

---
 rtl/fifo_resultados_div.sv | 88 ++++++++
 tb/tb_fifo_resultados_div.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_resultados_div.sv
// Result buffer behind the pipelined divider: a first-word-fall-through FIFO for {Coc, Res}
// pairs, plus tracking of in-flight divisions that yields an issue credit for Start.
module fifo_resultados_div #(
  parameter int tamanyo = 32,
  parameter int PROF    = 8
) (
  input  logic                   CLK,
  input  logic                   RSTa,
  input  logic                   Start_in,
  input  logic                   Done_in,
  input  logic [tamanyo-1:0]     Coc_in,
  input  logic [tamanyo-1:0]     Res_in,
  output logic                   Out_valid,
  input  logic                   Out_ready,
  output logic [tamanyo-1:0]     Coc_out,
  output logic [tamanyo-1:0]     Res_out,
  output logic [$clog2(PROF):0]  Cuenta,
  output logic [$clog2(PROF):0]  En_vuelo,
  output logic                   Puede_empezar,
  output logic                   Overflow,
  output logic                   Violacion
);

  localparam int AW = $clog2(PROF);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LLENO = CW'(PROF);

  logic [2*tamanyo-1:0] mem [PROF];
  logic [2*tamanyo-1:0] head;
  logic [AW-1:0]        wp;
  logic [AW-1:0]        rp;
  logic                 pop;
  logic                 push;
  logic [CW:0]          ocupado;

  // In-flight count: saturates at PROF on issue, floors at 0 on return.
  function automatic logic [CW-1:0] vuelo_sig(input logic [CW-1:0] v,
                                               input logic st, input logic dn);
    logic [CW-1:0] r;
    r = v;
    if (st && !dn && v != LLENO)
      r = v + 1'b1;
    else if (dn && !st && v != '0)
      r = v - 1'b1;
    return r;
  endfunction

  assign head          = mem[rp];
  assign Out_valid     = (Cuenta != '0);
  assign Coc_out       = Out_valid ? head[2*tamanyo-1:tamanyo] : '0;
  assign Res_out       = Out_valid ? head[tamanyo-1:0] : '0;
  assign pop           = Out_valid & Out_ready;
  assign push          = Done_in & ~RSTa & ((Cuenta != LLENO) | pop);
  assign ocupado       = {1'b0, Cuenta} + {1'b0, En_vuelo};
  assign Puede_empezar = (ocupado < {1'b0, LLENO});

  always_ff @(posedge CLK) begin
    if (push)
      mem[wp] <= {Coc_in, Res_in};
  end

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      wp        <= '0;
      rp        <= '0;
      Cuenta    <= '0;
      En_vuelo  <= '0;
      Overflow  <= 1'b0;
      Violacion <= 1'b0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (push && !pop)
        Cuenta <= Cuenta + 1'b1;
      else if (pop && !push)
        Cuenta <= Cuenta - 1'b1;
      En_vuelo <= vuelo_sig(En_vuelo, Start_in, Done_in);
      // A result that finds the FIFO full with no pop to make room is lost.
      if (Done_in && !push)
        Overflow <= 1'b1;
      if ((Start_in && !Puede_empezar) || (Done_in && !Start_in && En_vuelo == '0))
        Violacion <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_resultados_div.sv
// Bench for fifo_resultados_div: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model.
module tb_fifo_resultados_div;

  localparam int T = 32;
  localparam int P = 8;

  logic         CLK = 1'b0;
  logic         RSTa = 1'b0;
  logic         Start_in = 1'b0;
  logic         Done_in = 1'b0;
  logic [T-1:0] Coc_in = '0;
  logic [T-1:0] Res_in = '0;
  logic         Out_valid;
  logic         Out_ready = 1'b0;
  logic [T-1:0] Coc_out;
  logic [T-1:0] Res_out;
  logic [$clog2(P):0] Cuenta;
  logic [$clog2(P):0] En_vuelo;
  logic         Puede_empezar;
  logic         Overflow;
  logic         Violacion;

  fifo_resultados_div #(.tamanyo(T), .PROF(P)) dut (
    .CLK(CLK), .RSTa(RSTa), .Start_in(Start_in), .Done_in(Done_in),
    .Coc_in(Coc_in), .Res_in(Res_in), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Coc_out(Coc_out), .Res_out(Res_out), .Cuenta(Cuenta), .En_vuelo(En_vuelo),
    .Puede_empezar(Puede_empezar), .Overflow(Overflow), .Violacion(Violacion)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [2*T-1:0] q[$];
  int  inflight = 0;
  bit  m_ovf = 0;
  bit  m_viol = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the FIFO is a queue, the credit a plain integer.
  task automatic model_step(input bit rst, input bit st, input bit dn,
                            input logic [T-1:0] c, input logic [T-1:0] r, input bit rdy);
    int  cnt;
    bit  pe, pp, ok;
    if (rst) begin
      q.delete();
      inflight = 0;
      m_ovf = 0;
      m_viol = 0;
      return;
    end
    cnt = q.size();
    pe  = (cnt + inflight) < P;
    pp  = (cnt > 0) && rdy;
    ok  = dn && (cnt < P || pp);
    if (st && !pe) m_viol = 1;
    if (dn && !st && inflight == 0) m_viol = 1;
    if (dn && !ok) m_ovf = 1;
    if (pp) void'(q.pop_front());
    if (ok) q.push_back({c, r});
    if (st && !dn) inflight = (inflight + 1 > P) ? P : inflight + 1;
    else if (dn && !st) inflight = (inflight > 0) ? inflight - 1 : 0;
  endtask

  task automatic cycle(input bit rst, input bit st, input bit dn,
                       input logic [T-1:0] c, input logic [T-1:0] r, input bit rdy);
    logic [2*T-1:0] h;
    RSTa = rst; Start_in = st; Done_in = dn; Coc_in = c; Res_in = r; Out_ready = rdy;
    model_step(rst, st, dn, c, r, rdy);
    @(posedge CLK);
    @(negedge CLK);
    RSTa = 0; Start_in = 0; Done_in = 0; Out_ready = 0;
    h = (q.size() > 0) ? q[0] : '0;
    chk("valid",   64'(Out_valid),     64'(q.size() > 0));
    chk("coc",     64'(Coc_out),       64'(h[2*T-1:T]));
    chk("res",     64'(Res_out),       64'(h[T-1:0]));
    chk("cuenta",  64'(Cuenta),        64'(q.size()));
    chk("vuelo",   64'(En_vuelo),      64'(inflight));
    chk("puede",   64'(Puede_empezar), 64'((q.size() + inflight) < P));
    chk("ovf",     64'(Overflow),      64'(m_ovf));
    chk("viol",    64'(Violacion),     64'(m_viol));
  endtask

  task automatic reset_dut();
    cycle(1, 0, 0, '0, '0, 0);
  endtask

  initial begin
    logic [T-1:0] prev;
    reset_dut();
    chk("rst_valid", 64'(Out_valid), 64'd0);
    chk("rst_puede", 64'(Puede_empezar), 64'd1);

    // Single result, consumer always ready
    cycle(0, 0, 1, 32'd7, 32'd2, 1);
    chk("tp1_valid", 64'(Out_valid), 64'd1);
    chk("tp1_coc", 64'(Coc_out), 64'd7);
    chk("tp1_res", 64'(Res_out), 64'd2);
    cycle(0, 0, 0, '0, '0, 1);
    chk("tp1_empty", 64'(Out_valid), 64'd0);
    chk("tp1_cnt", 64'(Cuenta), 64'd0);

    // Fill, overflow, drain in order
    reset_dut();
    for (int i = 1; i <= P; i++) cycle(0, 0, 1, T'(i), T'(i + 50), 0);
    chk("full_cnt", 64'(Cuenta), 64'(P));
    chk("full_puede", 64'(Puede_empezar), 64'd0);
    cycle(0, 0, 1, 32'd9, 32'd0, 0);
    chk("ovf_set", 64'(Overflow), 64'd1);
    chk("ovf_cnt", 64'(Cuenta), 64'(P));
    for (int i = 1; i <= P; i++) begin
      chk("drain_ord", 64'(Coc_out), 64'(i));
      cycle(0, 0, 0, '0, '0, 1);
    end
    chk("drain_empty", 64'(Out_valid), 64'd0);

    // Push and pop together while full
    reset_dut();
    for (int i = 1; i <= P; i++) cycle(0, 0, 1, T'(i), '0, 0);
    cycle(0, 0, 1, 32'd100, 32'd1, 1);
    chk("fpp_cnt", 64'(Cuenta), 64'(P));
    chk("fpp_ovf", 64'(Overflow), 64'd0);
    for (int i = 0; i < P - 1; i++) cycle(0, 0, 0, '0, '0, 1);
    chk("fpp_last", 64'(Coc_out), 64'd100);
    cycle(0, 0, 0, '0, '0, 1);

    // Wrap-around at steady occupancy of 3
    reset_dut();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, T'(i), '0, 0);
    prev = '1;
    for (int i = 3; i < 23; i++) begin
      if (prev != '1) chk("wrap_incr", 64'(Coc_out > prev), 64'd1);
      prev = Coc_out;
      cycle(0, 0, 1, T'(i), '0, 1);
      chk("wrap_cnt", 64'(Cuenta), 64'd3);
    end

    // Credit accounting
    reset_dut();
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0, '0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, T'(i), '0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, '0, '0, 0);
    chk("cred_vuelo", 64'(En_vuelo), 64'd5);
    chk("cred_puede", 64'(Puede_empezar), 64'd0);
    chk("cred_noviol", 64'(Violacion), 64'd0);
    cycle(0, 1, 0, '0, '0, 0);
    chk("cred_viol", 64'(Violacion), 64'd1);
    chk("cred_vuelo6", 64'(En_vuelo), 64'd6);
    reset_dut();
    chk("rec_noviol", 64'(Violacion), 64'd0);
    cycle(0, 0, 1, 32'd3, 32'd4, 0);
    chk("rec_viol", 64'(Violacion), 64'd1);

    // Mid-operation reset
    reset_dut();
    for (int i = 0; i <= P; i++) cycle(0, 0, 1, T'(i + 1), '0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, '0, 1);
    cycle(0, 1, 0, '0, '0, 0);
    cycle(0, 1, 0, '0, '0, 0);
    chk("pre_cnt", 64'(Cuenta), 64'd4);
    chk("pre_vuelo", 64'(En_vuelo), 64'd2);
    chk("pre_ovf", 64'(Overflow), 64'd1);
    cycle(1, 1, 1, 32'd5, 32'd5, 1);
    chk("post_cnt", 64'(Cuenta), 64'd0);
    chk("post_valid", 64'(Out_valid), 64'd0);
    chk("post_coc", 64'(Coc_out), 64'd0);
    chk("post_ovf", 64'(Overflow), 64'd0);
    chk("post_puede", 64'(Puede_empezar), 64'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), T'($urandom), T'($urandom),
            ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
